regfile_write_stage: RTL

//  - Architectural register file, the consumer of the writeback control's write_reg/write_en pair.
//  - Holds 32 x 32-bit registers: $r0 is hardwired zero, $r30 is $rstatus, $r31 is $ra.
//  - Provides one synchronous write port and two combinational read ports for decode.
//  - Exports $rstatus directly so bex resolves without a read port.

---
 rtl/rf_pkg.sv | 15 +
 rtl/regfile_cell.sv | 24 ++
 rtl/regfile_write_stage.sv | 61 ++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared sizes, well-known register indices and types for the architectural register file.
package rf_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO    = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RSTATUS = 5'd30;
    localparam logic [ADDR_W-1:0] REG_RA      = 5'd31;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_cell.sv
// One register-file entry: DATA_W flops with asynchronous active-low clear and a write enable.
module regfile_cell #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_write_stage.sv
// 32x32 register file: one synchronous write port, two combinational read ports, $rstatus export.
// Define REGFILE_BYPASS_EN to forward the in-flight write to the read ports in the same cycle.
module regfile_write_stage
    import rf_pkg::*;
(
    input  logic     i_clock,
    input  logic     i_reset_n,
    input  logic     i_write_en,
    input  rf_addr_t i_write_reg,
    input  rf_data_t i_write_data,
    input  rf_addr_t i_read_reg_a,
    input  rf_addr_t i_read_reg_b,
    output rf_data_t o_read_data_a,
    output rf_data_t o_read_data_b,
    output rf_data_t o_rstatus
);

    rf_data_t            w_regs [NUM_REGS];
    logic [NUM_REGS-1:1] w_wr_sel;

    // $r0 has no storage; it is a constant zero.
    assign w_regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
        assign w_wr_sel[i] = i_write_en && (i_write_reg == rf_addr_t'(i));

        regfile_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .i_clk   (i_clock),
            .i_rst_n (i_reset_n),
            .i_en    (w_wr_sel[i]),
            .i_d     (i_write_data),
            .o_q     (w_regs[i])
        );
    end

    rf_data_t w_rd_a;
    rf_data_t w_rd_b;
    rf_data_t w_stat;

    assign w_rd_a = w_regs[i_read_reg_a];
    assign w_rd_b = w_regs[i_read_reg_b];
    assign w_stat = w_regs[REG_RSTATUS];

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_ok;

    // Storage is already cleared during reset, so only forwarding needs the reset gate.
    assign w_fwd_ok = i_reset_n && i_write_en && (i_write_reg != REG_ZERO);

    assign o_read_data_a = (w_fwd_ok && (i_write_reg == i_read_reg_a)) ? i_write_data : w_rd_a;
    assign o_read_data_b = (w_fwd_ok && (i_write_reg == i_read_reg_b)) ? i_write_data : w_rd_b;
    assign o_rstatus     = (w_fwd_ok && (i_write_reg == REG_RSTATUS))  ? i_write_data : w_stat;
`else
    assign o_read_data_a = w_rd_a;
    assign o_read_data_b = w_rd_b;
    assign o_rstatus     = w_stat;
`endif

endmodule
